// File: rtl/alpha_blend_compositor.sv
// ============================================================================
// Module   : alpha_blend_compositor
// Brief    : Pipelined straight-alpha "over" compositor of NUM_LAYERS RGBA
//            layers onto a background colour, valid/ready flow control.
//            Optional macro COMPOSITOR_LAYER_MASK_EN adds the layer_en port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alpha_blend_compositor #(
    parameter int COLOR_DEPTH = 8,
    parameter int NUM_LAYERS  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_LAYERS*4*COLOR_DEPTH-1:0] rgba_in,
    input  logic [3*COLOR_DEPTH-1:0]            bg_rgb,
    input  logic                                in_sof,
`ifdef COMPOSITOR_LAYER_MASK_EN
    input  logic [NUM_LAYERS-1:0]               layer_en,
`endif
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [3*COLOR_DEPTH-1:0]            out_rgb,
    output logic                                out_sof
);

    localparam int             CD = COLOR_DEPTH;
    localparam int             LW = 4 * CD;
    localparam int             RW = 3 * CD;
    localparam logic [CD-1:0]  M  = {CD{1'b1}};

    // Per channel: t = s*a + d*(M-a); x = t + 2^(CD-1); r = (x + (x>>CD)) >> CD.
    function automatic logic [RW-1:0] blend(input logic [LW-1:0] layer,
                                            input logic [RW-1:0] dst);
        logic [CD-1:0]   a;
        logic [2*CD-1:0] t;
        logic [2*CD:0]   x;
        logic [RW-1:0]   r;
        a = layer[CD-1:0];
        r = '0;
        for (int c = 0; c < 3; c++) begin
            t = (2*CD)'(layer[(c+1)*CD +: CD]) * (2*CD)'(a)
              + (2*CD)'(dst[c*CD +: CD]) * (2*CD)'(M - a);
            x = (2*CD+1)'(t) + (2*CD+1)'(1 << (CD-1));
            r[c*CD +: CD] = CD'((x + (x >> CD)) >> CD);
        end
        return r;
    endfunction

    logic                  adv;
    logic [LW-1:0]         in_layer    [NUM_LAYERS];
    logic [LW-1:0]         stage_layer [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] valid_q;
    logic [NUM_LAYERS-1:0] sof_q;
    logic [RW-1:0]         acc_q       [NUM_LAYERS];
    logic [RW-1:0]         acc_d       [NUM_LAYERS];

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = valid_q[NUM_LAYERS-1];
    assign out_sof   = sof_q[NUM_LAYERS-1];
    assign out_rgb   = acc_q[NUM_LAYERS-1];

    // A disabled layer is folded into alpha=0 before it enters its delay line.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_in
`ifdef COMPOSITOR_LAYER_MASK_EN
        assign in_layer[k] = {rgba_in[k*LW+CD +: RW],
                              layer_en[k] ? rgba_in[k*LW +: CD] : {CD{1'b0}}};
`else
        assign in_layer[k] = rgba_in[k*LW +: LW];
`endif
    end

    // Layer k is delayed k cycles so it meets its pixel's accumulator in stage k.
    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_dly
        if (k == 0) begin : g_direct
            assign stage_layer[k] = in_layer[k];
        end else begin : g_shift
            logic [LW-1:0] sh_q [k];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int j = 0; j < k; j++) sh_q[j] <= '0;
                end else if (adv) begin
                    sh_q[0] <= in_layer[k];
                    for (int j = 1; j < k; j++) sh_q[j] <= sh_q[j-1];
                end
            end
            assign stage_layer[k] = sh_q[k-1];
        end
    end

    always_comb begin
        acc_d[0] = blend(stage_layer[0], bg_rgb);
        for (int k = 1; k < NUM_LAYERS; k++) begin
            acc_d[k] = blend(stage_layer[k], acc_q[k-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            sof_q   <= '0;
            for (int k = 0; k < NUM_LAYERS; k++) acc_q[k] <= '0;
        end else if (adv) begin
            valid_q[0] <= in_valid;
            sof_q[0]   <= in_sof;
            for (int k = 1; k < NUM_LAYERS; k++) begin
                valid_q[k] <= valid_q[k-1];
                sof_q[k]   <= sof_q[k-1];
            end
            for (int k = 0; k < NUM_LAYERS; k++) acc_q[k] <= acc_d[k];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alpha_blend_compositor.sv
// ============================================================================
// Module   : tb_alpha_blend_compositor
// Brief    : Scoreboard bench for alpha_blend_compositor (CD=8, 4 layers).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alpha_blend_compositor;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] rgba_in = '0;
    logic [23:0]  bg_rgb = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_sof;
    logic [23:0]  out_rgb;
`ifdef COMPOSITOR_LAYER_MASK_EN
    logic [3:0]   layer_en = 4'hF;
`endif

    alpha_blend_compositor #(.COLOR_DEPTH(8), .NUM_LAYERS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rgba_in   (rgba_in),
        .bg_rgb    (bg_rgb),
        .in_sof    (in_sof),
`ifdef COMPOSITOR_LAYER_MASK_EN
        .layer_en  (layer_en),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rgb   (out_rgb),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          stall_cnt = 0;
    logic [24:0] exp_q[$];
    logic [127:0] vrgba [6];
    logic [23:0]  vbg   [6];
    logic [23:0]  vexp  [6];

    function automatic logic [31:0] lay(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b, input logic [7:0] a);
        return {r, g, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks hold behaviour.
    initial begin
        logic        prev_hold;
        logic [24:0] prev_out;
        logic [24:0] e;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (!in_ready) stall_cnt++;
                if (prev_hold) begin
                    n_cmp++;
                    if (!out_valid || {out_sof, out_rgb} !== prev_out) begin
                        n_err++;
                        $display("FAIL hold: got v=%b %h expected v=1 %h", out_valid,
                                 {out_sof, out_rgb}, prev_out);
                    end
                end
                if (out_valid && !out_ready) begin
                    n_cmp++;
                    if (in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL in_ready_stall: got %b expected 0", in_ready);
                    end
                end
                if (out_valid && out_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_output: got %h expected none", {out_sof, out_rgb});
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_sof, out_rgb} !== e) begin
                            n_err++;
                            $display("FAIL pixel%0d: got sof=%b rgb=%h expected sof=%b rgb=%h",
                                     n_out, out_sof, out_rgb, e[24], e[23:0]);
                        end
                    end
                    n_out++;
                end
                prev_hold = out_valid && !out_ready;
                prev_out  = {out_sof, out_rgb};
            end
        end
    end

    task automatic send(input logic [127:0] rgba, input logic [23:0] bg,
                        input logic sof, input logic [23:0] exp_rgb);
        int   t;
        logic rdy;
        t = 0;
        rgba_in  = rgba;
        bg_rgb   = bg;
        in_sof   = sof;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 100);
        if (!rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end else begin
            exp_q.push_back({sof, exp_rgb});
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic lat_check(input string name);
        int cnt;
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(name, cnt, 4);
        @(posedge clk);
        #1;
        chk({name, "_pulse"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

`ifdef COMPOSITOR_LAYER_MASK_EN
    function automatic logic [23:0] model(input logic [127:0] rgba, input logic [23:0] bg,
                                          input logic [3:0] en);
        logic [23:0] acc;
        int a, s, d, t, x, r;
        acc = bg;
        for (int k = 0; k < 4; k++) begin
            a = en[k] ? int'(rgba[k*32 +: 8]) : 0;
            for (int c = 0; c < 3; c++) begin
                s = int'(rgba[k*32 + 8 + c*8 +: 8]);
                d = int'(acc[c*8 +: 8]);
                t = s * a + d * (255 - a);
                x = t + 128;
                r = (x + (x >> 8)) >> 8;
                acc[c*8 +: 8] = r[7:0];
            end
        end
        return acc;
    endfunction
`endif

    initial begin
        logic [7:0] bi;
        int         n0;
        vrgba[0] = {lay(8'hFF,8'hFF,8'hFF,8'h00), lay(8'hAA,8'hBB,8'hCC,8'h00),
                    lay(8'h11,8'h22,8'h33,8'h00), lay(8'h44,8'h55,8'h66,8'h00)};
        vbg[0] = 24'h123456; vexp[0] = 24'h123456;
        vrgba[1] = {32'h0, lay(8'hFF,8'h00,8'h00,8'h80), 32'h0, 32'h0};
        vbg[1] = 24'h000000; vexp[1] = 24'h800000;
        vrgba[2] = {lay(8'h00,8'hFF,8'h00,8'hFF), lay(8'hFF,8'h00,8'h00,8'h80), 32'h0, 32'h0};
        vbg[2] = 24'h000000; vexp[2] = 24'h00FF00;
        vrgba[3] = {32'h0, 32'h0, 32'h0, lay(8'hC8,8'h64,8'h32,8'h40)};
        vbg[3] = 24'h102030; vexp[3] = 24'h3E3131;
        vrgba[4] = {lay(8'h00,8'h00,8'h00,8'h80), 32'h0, lay(8'hFF,8'hFF,8'hFF,8'hFF), 32'h0};
        vbg[4] = 24'h0A0B0C; vexp[4] = 24'h7F7F7F;
        vrgba[5] = {32'h0, 32'h0, lay(8'h00,8'hFF,8'h00,8'h80), lay(8'hFF,8'h00,8'h00,8'h80)};
        vbg[5] = 24'h000000; vexp[5] = 24'h408000;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_rgb", {8'd0, out_rgb}, 32'd0);
        chk("reset_out_sof", {31'd0, out_sof}, 32'd0);

        // Transparent layers pass the background with fixed latency.
        send(vrgba[0], vbg[0], 1'b0, vexp[0]);
        lat_check("latency_transparent");

        for (int i = 1; i < 6; i++) begin
            send(vrgba[i], vbg[i], 1'b0, vexp[i]);
            repeat (6) @(posedge clk);
            #1;
        end
        drain();

        // Back-to-back stream with sof on the first pixel only.
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            bi = 8'(i);
            if (i % 2 == 0)
                send(vrgba[0], {bi, bi ^ 8'hA5, bi + 8'h30}, i == 0, {bi, bi ^ 8'hA5, bi + 8'h30});
            else
                send(vrgba[(i/2) % 6], vbg[(i/2) % 6], 1'b0, vexp[(i/2) % 6]);
        end
        drain();
        chk("stream_count", n_out - n0, 16);

        // Five-cycle output stall in the middle of a stream.
        stall_cnt = 0;
        n0 = n_out;
        fork
            for (int i = 0; i < 12; i++) begin
                bi = 8'(i * 7);
                send(vrgba[i % 6], (i % 6 == 0) ? {bi, 8'h5A, ~bi} : vbg[i % 6],
                     1'b0, (i % 6 == 0) ? {bi, 8'h5A, ~bi} : vexp[i % 6]);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_in_ready_cycles", stall_cnt, 5);
        chk("stall_count", n_out - n0, 12);

        // Reset with three pixels in flight: nothing may emerge.
        for (int i = 0; i < 3; i++) send(vrgba[i + 1], vbg[i + 1], 1'b0, vexp[i + 1]);
        rst_n = 1'b0;
        exp_q.delete();
        n0 = n_out;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midreset_no_output", n_out - n0, 0);
        send(vrgba[3], vbg[3], 1'b1, vexp[3]);
        lat_check("latency_after_reset");
        drain();

`ifdef COMPOSITOR_LAYER_MASK_EN
        layer_en = 4'b0111;
        send({lay(8'hFF,8'hFF,8'hFF,8'hFF), 96'h0}, 24'h0000FF, 1'b0, 24'h0000FF);
        drain();
        layer_en = 4'b1111;
        send({lay(8'hFF,8'hFF,8'hFF,8'hFF), 96'h0}, 24'h0000FF, 1'b0, 24'hFFFFFF);
        drain();
        for (int i = 0; i < 10000; i++) begin
            logic [127:0] rr;
            logic [23:0]  bb;
            rr = {$urandom, $urandom, $urandom, $urandom};
            bb = 24'($urandom);
            layer_en = 4'($urandom);
            send(rr, bb, 1'b0, model(rr, bb, layer_en));
        end
        drain();
        layer_en = 4'hF;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
